jpeg_output_y_writer: RTL
=========================

# jpeg_output_y_writer

Producer side of the Y output block buffer. Accepts one 8x8 block of IDCT luma results per 64 accepted samples, level-shifts and clamps each to 8 bits, and issues indexed pushes (`push_o`/`wr_idx_o`/`data_o`) into the 512-entry (8-block) Y output buffer. It sits between the IDCT output and that buffer, and gates block starts on the buffer's reported occupancy so the buffer never overflows.

## Interface
- No parameters. Block size is fixed at 64; buffer capacity is fixed at 512 entries.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `in_valid_i` input 1: IDCT sample valid.
- `in_data_i` input 16: signed IDCT sample, before level shift.
- `in_ready_o` output 1: sample accepted when `in_valid_i && in_ready_o`.
- `level_i` input 32: buffer occupancy in entries, from the buffer's level output.
- `flush_req_i` input 1: request to flush the buffer at a frame start.
- `push_o` output 1: buffer write strobe.
- `wr_idx_o` output 6: position within the current block.
- `data_o` output 32: `{24'b0, pixel[7:0]}`.
- `flush_o` output 1: one-cycle buffer flush pulse.
- `block_done_o` output 1: pulses with the 64th push of a block.
- `blocks_o` output 16: count of completed blocks since reset or flush; wraps.

## Operation
- States:
  - IDLE: sample count `idx` = 0.
  - ACTIVE: `idx` 1..63.
  - FLUSH: lasts one cycle.
- Sample count `idx[5:0]` increments on each accept.
- The IDCT delivers samples in column-major order, so sample k = col*8 + row.
- Pixel value: `p = in_data_i + 128`, computed at 17 bits signed.
  - p < 0 → 0.
  - p > 255 → 255.
  - Otherwise → p[7:0].
- Space rule, applied only at a block start (state IDLE): `in_ready_o = (level_i + push_o) <= 448`.
  - The `push_o` term counts a push still in flight that `level_i` does not yet reflect.
  - When this holds, all 64 entries of the block fit.
- ACTIVE: `in_ready_o` = 1 unconditionally. A block, once started, is never stalled by the writer.
- Accept at `idx` = 63: `idx` wraps to 0, state returns to IDLE, `blocks_o` increments (modulo 2^16).
- Flush:
  - `flush_req_i` is honoured only in IDLE with `push_o` = 0.
  - In FLUSH: `flush_o` = 1, `in_ready_o` = 0, `blocks_o` cleared. Next state is IDLE.
  - A `flush_req_i` arriving in ACTIVE is held pending and taken after the block completes.
  - A block start and a flush never coincide; flush has priority in IDLE.
- The writer pushes exactly 64 entries per block, contiguously in block order. The buffer derives the block base from its own write pointer, so a partial block is illegal and cannot occur except by reset.

## Timing
- Reset (`rst_ni` = 0 at a clock edge) sets:
  - state IDLE, `idx` = 0, pending flush cleared;
  - `push_o` = 0, `wr_idx_o` = 0, `data_o` = 0, `flush_o` = 0, `block_done_o` = 0, `blocks_o` = 0;
  - `in_ready_o` = 0 for the cycle of reset.
- Reset mid-block abandons the block. No further pushes follow.
- Latency: an accept at edge N drives `push_o`, `wr_idx_o` and `data_o` registered for cycle N+1. All outputs are registered except `in_ready_o`.
- `block_done_o` is aligned with the push of entry 63.
- Back-to-back operation: 64 consecutive accepts give 64 consecutive pushes.
  - The next block may start the cycle after the 64th accept, if space permits.
  - Peak throughput is one sample per cycle.
- `in_valid_i` low in ACTIVE inserts bubbles. `push_o` = 0 in those cycles and `idx` holds.

## Configuration
- `JPEG_OUT_TRANSPOSE_EN` defined: `wr_idx_o` = {idx[2:0], idx[5:3]}, i.e. row*8 + col. Column-major input lands raster-ordered in the buffer.
- Not defined: `wr_idx_o` = idx. Input order is preserved; used when the IDCT already emits row-major order.
- Nothing else differs between the two builds.

## Test plan
- Reset, then 64 samples of `in_data_i` = k − 128 for k = 0..63, `level_i` = 0:
  - with the macro: pushes 1..64 cycles later, `data_o` = k, `wr_idx_o` = {k[2:0], k[5:3]};
  - `block_done_o` high with the final push; `blocks_o` = 1.
- Clamp: `in_data_i` = −300 → `data_o` = 0; 127 → 255; 200 → 255; −128 → 0; 0 → 128.
- Space gating: in IDLE with `level_i` = 449, `in_ready_o` = 0. Drop `level_i` to 448 → accept the next cycle. With `level_i` = 448 and `push_o` = 1 → `in_ready_o` = 0.
- Flush: `flush_req_i` asserted at `idx` = 30 → block completes all 64 pushes, then one cycle of `flush_o` = 1 with `in_ready_o` = 0, then `blocks_o` = 0.
- Bubbles and reset: randomly toggle `in_valid_i` → exactly 64 pushes with indices in order. Assert `rst_ni` = 0 at `idx` = 10 → no pushes after reset and all outputs 0.

Source files
------------

// File: rtl/jpeg_output_y_writer.sv
// jpeg_output_y_writer
//   Producer side of the Y output block buffer. Takes 64 IDCT luma samples per
//   8x8 block, level-shifts (+128) and clamps each to 8 bits, and issues indexed
//   pushes into the 512-entry buffer. A block only starts when all 64 entries
//   are known to fit; once started it runs to completion.
//
//   Build option: JPEG_OUT_TRANSPOSE_EN
//     defined   -> wr_idx_o = {idx[2:0], idx[5:3]} (column-major in, raster out)
//     undefined -> wr_idx_o = idx
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   in_valid_i/in_data_i IDCT sample stream (signed 16-bit, before level shift)
//   in_ready_o           sample accepted when in_valid_i && in_ready_o
//   level_i              buffer occupancy in entries
//   flush_req_i          flush request (taken between blocks)
//   push_o/wr_idx_o/data_o  registered buffer write
//   flush_o              one-cycle buffer flush pulse
//   block_done_o         high with the push of entry 63
//   blocks_o             completed blocks since reset/flush, wraps
//
// state  | meaning
// IDLE   | between blocks, idx = 0, waiting for space or flush
// ACTIVE | inside a block, idx = 1..63, never stalls
// FLUSH  | one cycle of flush_o, blocks_o cleared
module jpeg_output_y_writer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  input  logic [31:0] level_i,
  input  logic        flush_req_i,
  output logic        push_o,
  output logic [5:0]  wr_idx_o,
  output logic [31:0] data_o,
  output logic        flush_o,
  output logic        block_done_o,
  output logic [15:0] blocks_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH} state_e;

  state_e       state_q;
  logic [5:0]   idx_q;
  logic         flush_pend_q;
  logic         push_q;
  logic [5:0]   widx_q;
  logic [7:0]   pix_q;
  logic         flush_q;
  logic         done_q;
  logic [15:0]  blocks_q;

  logic         flush_want;
  logic         flush_take;
  logic [32:0]  level_sum;
  logic         space_ok;
  logic         accept;
  logic signed [16:0] pix_sum;
  logic [7:0]   pix_d;
  logic [5:0]   widx_d;

  assign flush_want = flush_req_i | flush_pend_q;
  // A push in flight is not yet in level_i, so the flush waits for it too.
  assign flush_take = (state_q == ST_IDLE) && flush_want && !push_q;

  // The in-flight push is added so a block never starts on a stale level.
  assign level_sum = {1'b0, level_i} + {32'b0, push_q};
  assign space_ok  = (level_sum <= 33'd448);

  always_comb begin
    in_ready_o = 1'b0;
    if (rst_ni) begin
      case (state_q)
        ST_IDLE:   in_ready_o = space_ok && !flush_want;
        ST_ACTIVE: in_ready_o = 1'b1;
        default:   in_ready_o = 1'b0;
      endcase
    end
  end

  assign accept = in_valid_i && in_ready_o;

  assign pix_sum = $signed({in_data_i[15], in_data_i}) + 17'sd128;

  always_comb begin
    if (pix_sum[16])
      pix_d = 8'd0;
    else if (pix_sum[15:8] != 8'd0)
      pix_d = 8'd255;
    else
      pix_d = pix_sum[7:0];
  end

`ifdef JPEG_OUT_TRANSPOSE_EN
  assign widx_d = {idx_q[2:0], idx_q[5:3]};
`else
  assign widx_d = idx_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      idx_q        <= 6'd0;
      flush_pend_q <= 1'b0;
      push_q       <= 1'b0;
      widx_q       <= 6'd0;
      pix_q        <= 8'd0;
      flush_q      <= 1'b0;
      done_q       <= 1'b0;
      blocks_q     <= 16'd0;
    end else begin
      push_q  <= accept;
      done_q  <= 1'b0;
      flush_q <= 1'b0;
      if (accept) begin
        widx_q <= widx_d;
        pix_q  <= pix_d;
        idx_q  <= idx_q + 6'd1;
      end
      if (flush_req_i && !flush_take)
        flush_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (flush_take) begin
            state_q      <= ST_FLUSH;
            flush_q      <= 1'b1;
            blocks_q     <= 16'd0;
            flush_pend_q <= 1'b0;
          end else if (accept) begin
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (accept && idx_q == 6'd63) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b1;
            blocks_q <= blocks_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign push_o       = push_q;
  assign wr_idx_o     = widx_q;
  assign data_o       = {24'b0, pix_q};
  assign flush_o      = flush_q;
  assign block_done_o = done_q;
  assign blocks_o     = blocks_q;

endmodule
